bus_arbiter_rr: RTL and testbench

Parametrised round-robin bus arbiter with single-outstanding split-transaction support. It replaces the fixed two-initiator priority arbitration inside the serial bus. It scales to `NUM_INIT` initiators, parks a split initiator, and returns the bus to the split target with priority. An optional watchdog reclaims a hung bus. It sits between the initiator request lines and the bus mux/decoder, which consume `owner_idx` and `grant`.

---
 rtl/bus_arb_pkg.sv | 21 ++
 rtl/rr_priority_picker.sv | 44 ++++
 rtl/bus_arbiter_rr.sv | 153 +++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// ============================================================================
// Module      : bus_arb_pkg
// Description : Shared types and limits for the round-robin bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        OWNED        = 2'd1,
        SPLIT_RESUME = 2'd2
    } arb_state_t;

    localparam int BUS_ARB_MAX_INIT        = 8;
    localparam int BUS_ARB_DEFAULT_TIMEOUT = 1024;

endpackage : bus_arb_pkg

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational rotating priority encoder; first unmasked
//               request at or above 'base' (wrapping) wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_picker #(
    parameter int NUM_INIT = 2,
    parameter int IDX_W    = $clog2(NUM_INIT)
) (
    input  logic [NUM_INIT-1:0] req,
    input  logic [NUM_INIT-1:0] mask,
    input  logic [IDX_W-1:0]    base,
    output logic                valid,
    output logic [IDX_W-1:0]    idx
);

    logic [NUM_INIT-1:0] w_rot;
    logic [IDX_W:0]      w_sum;

    // Rotate so that bit 0 of w_rot corresponds to position 'base'.
    assign w_rot = NUM_INIT'({(req & ~mask), (req & ~mask)} >> base);

    // Scan downward so the lowest rotated offset is the last (winning) write.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        w_sum = '0;
        for (int i = NUM_INIT - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                valid = 1'b1;
                w_sum = {1'b0, base} + (IDX_W + 1)'(i);
                idx   = (w_sum >= (IDX_W + 1)'(NUM_INIT))
                        ? IDX_W'(w_sum - (IDX_W + 1)'(NUM_INIT))
                        : IDX_W'(w_sum);
            end
        end
    end

endmodule : rr_priority_picker

`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
// ============================================================================
// Module      : bus_arbiter_rr
// Description : Round-robin bus arbiter with single-outstanding split support.
//               Optional watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NUM_INIT       = 2,
    parameter int TIMEOUT_CYCLES = BUS_ARB_DEFAULT_TIMEOUT,
    parameter int IDX_W          = $clog2(NUM_INIT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_INIT-1:0] init_req,
    output logic [NUM_INIT-1:0] init_grant,
    input  logic                txn_done,
    input  logic                split_ack,
    input  logic                split_req,
    output logic                split_grant,
    output logic [IDX_W-1:0]    owner_idx,
    output logic                split_pending,
    output logic                timeout
);

    localparam logic [NUM_INIT-1:0] c_ONE  = NUM_INIT'(1);
    localparam logic [IDX_W-1:0]    c_LAST = IDX_W'(NUM_INIT - 1);

    if (NUM_INIT < 2 || NUM_INIT > BUS_ARB_MAX_INIT || TIMEOUT_CYCLES < 16) begin : g_bad_params
        $error("bus_arbiter_rr: NUM_INIT must be 2..8 and TIMEOUT_CYCLES >= 16");
    end

    arb_state_t          r_state;
    logic [NUM_INIT-1:0] r_init_grant;
    logic                r_split_grant;
    logic [IDX_W-1:0]    r_owner_idx;
    logic [IDX_W-1:0]    r_last_owner;
    logic [IDX_W-1:0]    r_split_owner;
    logic                r_split_pending;
    logic                r_timeout;

    logic [IDX_W-1:0]    w_base;
    logic [NUM_INIT-1:0] w_mask;
    logic                w_pick_valid;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_wdog_expire;

    assign w_base = (r_last_owner == c_LAST) ? '0 : r_last_owner + IDX_W'(1);
    assign w_mask = r_split_pending ? (c_ONE << r_split_owner) : '0;

    rr_priority_picker #(
        .NUM_INIT (NUM_INIT),
        .IDX_W    (IDX_W)
    ) u_picker (
        .req   (init_req),
        .mask  (w_mask),
        .base  (w_base),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_wdog_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_wdog_cnt <= '0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + c_CNT_W'(1);
        end
    end

    assign w_wdog_expire = (r_wdog_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_wdog_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_init_grant    <= '0;
            r_split_grant   <= 1'b0;
            r_owner_idx     <= '0;
            r_last_owner    <= c_LAST;
            r_split_owner   <= '0;
            r_split_pending <= 1'b0;
            r_timeout       <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_split_pending && split_req) begin
                        r_state       <= SPLIT_RESUME;
                        r_split_grant <= 1'b1;
                        r_init_grant  <= c_ONE << r_split_owner;
                        r_owner_idx   <= r_split_owner;
                    end else if (w_pick_valid) begin
                        r_state      <= OWNED;
                        r_init_grant <= c_ONE << w_pick_idx;
                        r_owner_idx  <= w_pick_idx;
                        r_last_owner <= w_pick_idx;
                    end
                end
                OWNED: begin
                    if (split_ack && !r_split_pending) begin
                        r_split_owner   <= r_owner_idx;
                        r_split_pending <= 1'b1;
                        r_init_grant    <= '0;
                        r_state         <= IDLE;
                    end else if (split_ack || txn_done || !init_req[r_owner_idx]) begin
                        // A second split is treated as a plain completion.
                        r_init_grant <= '0;
                        r_state      <= IDLE;
                    end else if (w_wdog_expire) begin
                        r_init_grant <= '0;
                        r_timeout    <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                SPLIT_RESUME: begin
                    if (txn_done || w_wdog_expire) begin
                        r_split_pending <= 1'b0;
                        r_split_grant   <= 1'b0;
                        r_init_grant    <= '0;
                        r_timeout       <= !txn_done;
                        r_state         <= IDLE;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_init_grant  <= '0;
                    r_split_grant <= 1'b0;
                end
            endcase
        end
    end

    assign init_grant    = r_init_grant;
    assign split_grant   = r_split_grant;
    assign owner_idx     = r_owner_idx;
    assign split_pending = r_split_pending;
    assign timeout       = r_timeout;

endmodule : bus_arbiter_rr

`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
// ============================================================================
// Module      : tb_bus_arbiter_rr
// Description : Directed-vector bench for bus_arbiter_rr (NUM_INIT=4,
//               TIMEOUT_CYCLES=16); watchdog vectors follow BUS_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] init_req;
    logic [3:0] init_grant;
    logic       txn_done;
    logic       split_ack;
    logic       split_req;
    logic       split_grant;
    logic [1:0] owner_idx;
    logic       split_pending;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter_rr #(
        .NUM_INIT       (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_req      (init_req),
        .init_grant    (init_grant),
        .txn_done      (txn_done),
        .split_ack     (split_ack),
        .split_req     (split_req),
        .split_grant   (split_grant),
        .owner_idx     (owner_idx),
        .split_pending (split_pending),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic       sack;
        logic       sreq;
        logic [3:0] eg;
        logic       esg;
        logic [1:0] eo;
        logic       ep;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] req, input logic done, input logic sack, input logic sreq,
                       input logic [3:0] eg, input logic esg, input logic [1:0] eo, input logic ep);
        vec_t v;
        v.req = req; v.done = done; v.sack = sack; v.sreq = sreq;
        v.eg = eg; v.esg = esg; v.eo = eo; v.ep = ep;
        vt.push_back(v);
    endtask

    // Drive inputs just after a falling edge; returns after the next falling edge.
    task automatic step(input logic [3:0] req, input logic done, input logic sack, input logic sreq);
        init_req  = req;
        txn_done  = done;
        split_ack = sack;
        split_req = sreq;
        @(negedge clk);
    endtask

    task automatic chk_out(input string name, input int row, input logic [3:0] eg, input logic esg,
                           input logic [1:0] eo, input logic ep, input logic et);
        chk({name, ".grant"}, row, 32'(init_grant), 32'(eg));
        chk({name, ".split_grant"}, row, 32'(split_grant), 32'(esg));
        if (eg != 4'b0000) chk({name, ".owner"}, row, 32'(owner_idx), 32'(eo));
        chk({name, ".pending"}, row, 32'(split_pending), 32'(ep));
        chk({name, ".timeout"}, row, 32'(timeout), 32'(et));
    endtask

    initial begin
        // Round robin 0,1,2,3,0 with done three cycles after each grant.
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 3; k++) add(4'hF, 1'b0, 1'b0, 1'b0, 4'(1 << g), 1'b0, 2'(g), 1'b0);
            add(4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
        end
        add(4'hF, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, 1'b0);
        add(4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
        // Split of initiator 2, others served around it, then resume.
        add(4'h4, 1'b0, 1'b0, 1'b0, 4'h4, 1'b0, 2'd2, 1'b0);
        add(4'h4, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
        add(4'hD, 1'b0, 1'b0, 1'b0, 4'h8, 1'b0, 2'd3, 1'b1);
        add(4'hD, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
        add(4'hD, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, 1'b1);
        add(4'hD, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
        add(4'hD, 1'b0, 1'b0, 1'b0, 4'h8, 1'b0, 2'd3, 1'b1);
        add(4'hD, 1'b0, 1'b0, 1'b1, 4'h8, 1'b0, 2'd3, 1'b1);
        add(4'hD, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1);
        add(4'hD, 1'b0, 1'b0, 1'b1, 4'h4, 1'b1, 2'd2, 1'b1);
        add(4'hD, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
        add(4'h9, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, 1'b0);
        add(4'h9, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
        // Resume beats a plain request in IDLE.
        add(4'h4, 1'b0, 1'b0, 1'b0, 4'h4, 1'b0, 2'd2, 1'b0);
        add(4'h4, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
        add(4'h1, 1'b0, 1'b0, 1'b1, 4'h4, 1'b1, 2'd2, 1'b1);
        add(4'h1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
        add(4'h1, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, 1'b0);
        add(4'h1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
        // Second split is a completion; parked owner stays initiator 1.
        add(4'h2, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 2'd1, 1'b0);
        add(4'h2, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
        add(4'h1, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, 1'b1);
        add(4'h1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1);
        add(4'h0, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1, 2'd1, 1'b1);
        add(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
        // Abandon: owner drops its request.
        add(4'h4, 1'b0, 1'b0, 1'b0, 4'h4, 1'b0, 2'd2, 1'b0);
        add(4'h4, 1'b0, 1'b0, 1'b0, 4'h4, 1'b0, 2'd2, 1'b0);
        add(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
        add(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
        // Sole requester: granted every other cycle.
        add(4'h1, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, 1'b0);
        add(4'h1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
        add(4'h1, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, 1'b0);
        add(4'h1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);

        rst_n = 1'b0;
        init_req = 4'h0; txn_done = 1'b0; split_ack = 1'b0; split_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("reset.owner_idx", 0, 32'(owner_idx), 32'd0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            step(vt[i].req, vt[i].done, vt[i].sack, vt[i].sreq);
            chk_out("vec", i, vt[i].eg, vt[i].esg, vt[i].eo, vt[i].ep, 1'b0);
        end

        // Asynchronous reset while initiator 1 owns with a split parked.
        step(4'h4, 1'b0, 1'b0, 1'b0);
        step(4'h4, 1'b0, 1'b1, 1'b0);
        step(4'h2, 1'b0, 1'b0, 1'b0);
        chk_out("pre_rst", 0, 4'h2, 1'b0, 2'd1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("async_rst.owner_idx", 0, 32'(owner_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'h3, 1'b0, 1'b0, 1'b0);
        chk_out("post_rst", 0, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'h0, 1'b1, 1'b0, 1'b0);
        chk_out("post_rst", 1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);

`ifdef BUS_ARB_TIMEOUT_EN
        step(4'h1, 1'b0, 1'b0, 1'b0);
        chk_out("wdog", 0, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int k = 1; k < 16; k++) begin
            step(4'h1, 1'b0, 1'b0, 1'b0);
            chk_out("wdog_hold", k, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        step(4'h1, 1'b0, 1'b0, 1'b0);
        chk_out("wdog_expire", 16, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1);
        step(4'h1, 1'b0, 1'b0, 1'b0);
        chk_out("wdog_regrant", 17, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int k = 1; k < 16; k++) begin
            step(4'h1, 1'b0, 1'b0, 1'b0);
            chk_out("wdog_hold2", k, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        step(4'h1, 1'b1, 1'b0, 1'b0);
        chk_out("wdog_done_wins", 16, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0, 1'b0);
        chk_out("wdog_after", 17, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
`else
        step(4'h1, 1'b0, 1'b0, 1'b0);
        chk_out("no_wdog", 0, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step(4'h1, 1'b0, 1'b0, 1'b0);
            chk_out("no_wdog_hold", k, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        step(4'h1, 1'b1, 1'b0, 1'b0);
        chk_out("no_wdog_done", 21, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
`endif

        step(4'h0, 1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bus_arbiter_rr

`default_nettype wire
